sd_dat_rx_ctrl: RTL and testbench
=================================

Name: sd_dat_rx_ctrl

Overview:
Receive-side sequencer for the 1-bit SD DAT path. It arms on a host command and detects the start bit on DAT0. It gates the serial-to-parallel deserializer word by word, counts words and blocks, and checks CRC16 and the end bit. It hands completed 32-bit words to the read FIFO and sits between the command engine and the DAT deserializer/FIFO.

Parameters:
BLOCK_BYTES, 512, bytes per data block; a multiple of 4, 4..2048.
TIMEOUT, 1024, clk cycles allowed in WAIT_START before a timeout error; >= 2.

Ports:
clk  in  1  SD bit clock; one DAT bit per cycle
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse; arms a transfer (ignored unless IDLE)
abort  in  1  single-cycle pulse; terminates any transfer
block_cnt  in  16  blocks to receive; sampled on start; 0 is treated as 1
dat_in  in  1  DAT0 line, already synchronised
ser_word  in  32  current parallel output of the external deserializer
ser_en  out  1  deserializer shift enable
ser_clr  out  1  deserializer clear
word_o  out  32  completed word
word_valid  out  1  word_o is valid; one-cycle pulse
fifo_full  in  1  downstream FIFO full
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; all blocks received without error
err  out  1  one-cycle pulse on any error
err_code  out  3  holds 0 none, 1 timeout, 2 crc, 3 end bit, 4 overrun until next start

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; err_code 0.
- States: IDLE, WAIT_START, DATA, CRC, END, NEXT.
- IDLE, on start:
  - latch block_cnt; clear err_code; pulse ser_clr for 1 cycle; go to WAIT_START.
- WAIT_START:
  - dat_in=0 is the start bit -> DATA; bit/word counters and CRC cleared.
  - Timeout counter increments each cycle. On reaching TIMEOUT-1 with no start bit -> err, err_code=1, IDLE.
- DATA:
  - ser_en=1 on every cycle; bit counter 0..31.
  - On bit 31: word_o <= {ser_word[30:0], dat_in}; word_valid pulses the following cycle.
  - If fifo_full=1 on bit 31 -> no word_valid; err, err_code=4, IDLE.
  - After BLOCK_BYTES/4 words -> CRC; ser_en=0 from that cycle.
- CRC: 16 cycles shifting dat_in into the received-CRC register, MSB first.
- END:
  - dat_in must be 1, else err code 3.
  - Else if the CRC mismatches, err code 2.
  - Else decrement remaining blocks: 0 -> done pulse, IDLE; nonzero -> NEXT.
- NEXT: ser_clr pulse; timeout counter cleared; -> WAIT_START.
- CRC: CRC16-CCITT, poly 0x1021, init 0x0000, MSB first, over data bits only.
- Errors: on any error, ser_en drops the same cycle and ser_clr pulses on entry to IDLE.
- abort:
  - From any non-IDLE state -> IDLE next cycle; ser_clr pulse.
  - No done or err; err_code unchanged.
  - abort has priority over all other events in the same cycle, including completion of a word.
- start while busy: ignored.
- reset mid-transfer: immediate return to reset values; no pulses emitted.
- Counter widths: words per block clog2(BLOCK_BYTES/4)+1; timeout counter clog2(TIMEOUT)+1; block counter 16 bits, with no wrap.

Optional Feature:
SD_DAT_RX_CRC_EN:
- Defined: CRC16 generated and checked as above; err_code 2 is possible.
- Undefined: no CRC logic. The CRC state still consumes 16 cycles, the CRC bits are discarded, and err_code 2 is never produced.

Decomposition:
- Package sd_dat_pkg:
  - state enum;
  - err_code constants (ERR_NONE/TIMEOUT/CRC/ENDBIT/OVERRUN);
  - CRC16 polynomial constant 16'h1021;
  - CRC_BITS=16.
- Sub-module sd_crc16: serial CRC16 with enable and clear, one bit per cycle. Also reused by the transmit path.

Test Plan:
- Single block, BLOCK_BYTES=8, data 0xDEADBEEF,0x01234567, correct CRC, end bit 1 -> two word_valid pulses with those values, done pulse, err never asserted.
- block_cnt=3, 5-cycle idle gap between blocks -> 3×(BLOCK_BYTES/4) word_valid pulses, a single done pulse after the third end bit, busy high throughout.
- No start bit for TIMEOUT=16 cycles -> err pulse at cycle 16 after start, err_code=1, busy low.
- One data bit flipped (CRC enabled) -> all words still pushed, err with err_code=2, no done; with macro undefined -> done.
- End bit 0 -> err_code=3; fifo_full=1 during the second word's bit 31 -> exactly one word_valid, err_code=4.
- abort in mid-DATA (bit 10 of word 1) -> IDLE next cycle, ser_clr pulse, no done or err; a subsequent start completes normally.

Source files
------------

// File: rtl/sd_dat_pkg.sv
// sd_dat_pkg: shared types and constants for the SD DAT receive/transmit path
package sd_dat_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, NEXT} state_t;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_ENDBIT  = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;
  localparam int CRC_BITS = 16;
  localparam logic [CRC_BITS-1:0] CRC_POLY = 16'h1021;
endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: serial CRC16-CCITT (init 0, MSB first), one bit per cycle
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the remainder to 0
//   en, din    : fold din into the remainder when en is high
//   crc        : current remainder
module sd_crc16 import sd_dat_pkg::*; (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                din,
  output logic [CRC_BITS-1:0] crc
);
  logic fb;
  assign fb = din ^ crc[CRC_BITS-1];
  always_ff @(posedge clk)
    if (reset || clr) crc <= '0;
    else if (en) crc <= {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
endmodule

// File: rtl/sd_dat_rx_ctrl.sv
// sd_dat_rx_ctrl: 1-bit SD DAT receive sequencer (start detect, word gating, CRC16/end-bit check)
//   start/abort/block_cnt : command-engine control; dat_in : DAT0 line
//   ser_word/ser_en/ser_clr : external deserializer interface
//   word_o/word_valid/fifo_full : read-FIFO interface
//   busy/done/err/err_code : status
//   Macro SD_DAT_RX_CRC_EN enables CRC16 generation and checking.
module sd_dat_rx_ctrl import sd_dat_pkg::*; #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] block_cnt,
  input  logic        dat_in,
  input  logic [31:0] ser_word,
  output logic        ser_en,
  output logic        ser_clr,
  output logic [31:0] word_o,
  output logic        word_valid,
  input  logic        fifo_full,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam int WORDS = BLOCK_BYTES / 4;
  localparam int WW = $clog2(WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_t state, state_n;
  logic [4:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0] blocks;
  logic [2:0] code;
  logic fin, bit_last, word_last, crc_bad, push;
  logic unused_msb;
  assign unused_msb = ser_word[31];
  assign bit_last = bit_cnt == 5'd31;
  assign word_last = word_cnt == WW'(WORDS - 1);
`ifdef SD_DAT_RX_CRC_EN
  logic [CRC_BITS-1:0] crc, rx_crc;
  sd_crc16 u_crc (
    .clk(clk), .reset(reset), .clr(state == WAIT_START), .en(ser_en), .din(dat_in), .crc(crc)
  );
  always_ff @(posedge clk)
    if (reset) rx_crc <= '0;
    else if (state == CRC) rx_crc <= {rx_crc[CRC_BITS-2:0], dat_in};
  assign crc_bad = rx_crc != crc;
`else
  assign crc_bad = 1'b0;
`endif
  always_comb begin
    state_n = state;
    code = ERR_NONE;
    fin = 1'b0;
    case (state)
      IDLE: state_n = start ? WAIT_START : IDLE;
      WAIT_START: begin
        if (!dat_in) state_n = DATA;
        else if (tmo_cnt == TW'(TIMEOUT - 1)) code = ERR_TIMEOUT;
      end
      DATA: begin
        if (bit_last && fifo_full) code = ERR_OVERRUN;
        else if (bit_last && word_last) state_n = CRC;
      end
      CRC: state_n = bit_cnt == 5'(CRC_BITS - 1) ? END : CRC;
      END: begin
        if (!dat_in) code = ERR_ENDBIT;
        else if (crc_bad) code = ERR_CRC;
        else if (blocks == 16'd1) fin = 1'b1;
        else state_n = NEXT;
      end
      NEXT: state_n = WAIT_START;
      default: state_n = IDLE;
    endcase
    if (code != ERR_NONE || fin) state_n = IDLE;
    // abort overrides every same-cycle event, including errors and completion
    if (abort && state != IDLE) begin
      state_n = IDLE;
      code = ERR_NONE;
      fin = 1'b0;
    end
  end
  assign ser_en = state == DATA && !abort && code == ERR_NONE;
  assign busy = state != IDLE;
  assign push = state == DATA && bit_last && !abort && !fifo_full;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      word_cnt <= '0;
      tmo_cnt <= '0;
      blocks <= '0;
      word_o <= '0;
      word_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      ser_clr <= 1'b0;
    end else begin
      word_valid <= push;
      if (push) word_o <= {ser_word[30:0], dat_in};
      done <= fin;
      err <= code != ERR_NONE;
      if (code != ERR_NONE) err_code <= code;
      ser_clr <= (state == IDLE && start) || (state == END && state_n == NEXT) ||
                 (state != IDLE && state_n == IDLE);
      if (state == IDLE && start) begin
        err_code <= ERR_NONE;
        blocks <= block_cnt == 16'd0 ? 16'd1 : block_cnt;
        tmo_cnt <= '0;
      end
      if (state == WAIT_START) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        bit_cnt <= '0;
        word_cnt <= '0;
      end
      if (state == NEXT) tmo_cnt <= '0;
      if (state == DATA || state == CRC) bit_cnt <= bit_cnt + 1'b1;
      if (state == DATA && bit_last) word_cnt <= word_cnt + 1'b1;
      if (state == END && state_n == NEXT) blocks <= blocks - 1'b1;
    end
  end
endmodule

// File: tb/tb_sd_dat_rx_ctrl.sv
// tb_sd_dat_rx_ctrl: directed self-checking bench for sd_dat_rx_ctrl (BLOCK_BYTES=8, TIMEOUT=16)
module tb_sd_dat_rx_ctrl;
  logic clk = 1'b0;
  logic reset, start, abort, dat_in, fifo_full;
  logic [15:0] block_cnt;
  logic [31:0] ser_word, word_o, sreg;
  logic ser_en, ser_clr, word_valid, busy, done, err;
  logic [2:0] err_code;
  int n_cmp = 0, n_fail = 0;
  int wv_cnt = 0, done_cnt = 0, err_cnt = 0, busy_drop = 0;
  int wv_b, done_b, err_b;
  logic watch = 1'b0;
  logic [31:0] words [0:31];
  sd_dat_rx_ctrl #(.BLOCK_BYTES(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .block_cnt(block_cnt),
    .dat_in(dat_in), .ser_word(ser_word), .ser_en(ser_en), .ser_clr(ser_clr),
    .word_o(word_o), .word_valid(word_valid), .fifo_full(fifo_full), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    sreg <= reset || ser_clr ? 32'd0 : ser_en ? {sreg[30:0], dat_in} : sreg;
  assign ser_word = sreg;
  always @(negedge clk) begin
    if (word_valid) begin
      if (wv_cnt < 32) words[wv_cnt] = word_o;
      wv_cnt++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (watch && !busy) busy_drop++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] crc_of(input logic [63:0] d);
    logic [15:0] c = 16'h0;
    for (int i = 63; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((d[i] ^ c[15]) ? 16'h1021 : 16'h0);
    return c;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    dat_in = b;
    tick();
  endtask
  task automatic mark();
    wv_b = wv_cnt;
    done_b = done_cnt;
    err_b = err_cnt;
  endtask
  task automatic go(input logic [15:0] cnt);
    mark();
    block_cnt = cnt;
    start = 1'b1;
    dat_in = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_block(input logic [63:0] d, input int flip_at, input int full_at,
                            input int abort_at, input logic endbit);
    logic [15:0] c;
    c = crc_of(d);
    send_bit(1'b0);
    for (int i = 0; i < 64; i++) begin
      fifo_full = i == full_at;
      abort = i == abort_at;
      send_bit(d[63-i] ^ (i == flip_at));
      if (i == abort_at) begin
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_clr", {31'd0, ser_clr}, 32'd1);
      end
    end
    fifo_full = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 16; i++) send_bit(c[15-i]);
    send_bit(endbit);
    dat_in = 1'b1;
  endtask
  task automatic check_words(input string tag, input int base, input logic [63:0] d);
    check({tag, "_w0"}, words[base], d[63:32]);
    check({tag, "_w1"}, words[base+1], d[31:0]);
  endtask
  initial begin
    logic [63:0] d1, d2, d3, d4;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dat_in = 1'b1;
    fifo_full = 1'b0;
    block_cnt = 16'd0;
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_code", {29'd0, err_code}, 32'd0);
    check("rst_ser", {29'd0, ser_en, ser_clr, word_valid}, 32'd0);
    reset = 1'b0;
    tick();
    // single block
    d1 = 64'hDEADBEEF_01234567;
    go(16'd1);
    check("t1_clr", {31'd0, ser_clr}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_block(d1, -1, -1, -1, 1'b1);
    check("t1_done_now", {31'd0, done}, 32'd1);
    tick();
    check("t1_wv", wv_cnt - wv_b, 2);
    check_words("t1", wv_b, d1);
    check("t1_done", done_cnt - done_b, 1);
    check("t1_err", err_cnt - err_b, 0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    // three blocks with idle gaps
    d2 = 64'hA5A5A5A5_5A5A5A5A;
    d3 = 64'h00000000_FFFFFFFF;
    d4 = 64'h80000001_7FFFFFFE;
    go(16'd3);
    watch = 1'b1;
    send_block(d2, -1, -1, -1, 1'b1);
    repeat (5) send_bit(1'b1);
    send_block(d3, -1, -1, -1, 1'b1);
    repeat (5) send_bit(1'b1);
    check("t2_no_early_done", done_cnt - done_b, 0);
    send_block(d4, -1, -1, -1, 1'b1);
    watch = 1'b0;
    tick();
    check("t2_wv", wv_cnt - wv_b, 6);
    check_words("t2a", wv_b, d2);
    check_words("t2b", wv_b + 2, d3);
    check_words("t2c", wv_b + 4, d4);
    check("t2_done", done_cnt - done_b, 1);
    check("t2_err", err_cnt - err_b, 0);
    check("t2_busy_drop", busy_drop, 0);
    // timeout with no start bit
    go(16'd1);
    repeat (15) tick();
    check("to_early_err", {31'd0, err}, 32'd0);
    check("to_early_busy", {31'd0, busy}, 32'd1);
    tick();
    check("to_err", {31'd0, err}, 32'd1);
    check("to_code", {29'd0, err_code}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_clr", {31'd0, ser_clr}, 32'd1);
    tick();
    check("to_err_pulse", {31'd0, err}, 32'd0);
    check("to_code_hold", {29'd0, err_code}, 32'd1);
    // one data bit flipped
    go(16'd1);
    check("crc_code_clr", {29'd0, err_code}, 32'd0);
    send_block(d1, 5, -1, -1, 1'b1);
    tick();
    check("crc_wv", wv_cnt - wv_b, 2);
    check("crc_w0", words[wv_b], d1[63:32] ^ 32'h0400_0000);
`ifdef SD_DAT_RX_CRC_EN
    check("crc_err", err_cnt - err_b, 1);
    check("crc_code", {29'd0, err_code}, 32'd2);
    check("crc_done", done_cnt - done_b, 0);
`else
    check("crc_err", err_cnt - err_b, 0);
    check("crc_code", {29'd0, err_code}, 32'd0);
    check("crc_done", done_cnt - done_b, 1);
`endif
    // end bit 0
    go(16'd1);
    send_block(d2, -1, -1, -1, 1'b0);
    tick();
    check("eb_code", {29'd0, err_code}, 32'd3);
    check("eb_err", err_cnt - err_b, 1);
    check("eb_done", done_cnt - done_b, 0);
    // fifo full on second word's last bit
    go(16'd1);
    send_block(d3, -1, 63, -1, 1'b1);
    tick();
    check("ov_wv", wv_cnt - wv_b, 1);
    check("ov_code", {29'd0, err_code}, 32'd4);
    check("ov_err", err_cnt - err_b, 1);
    check("ov_done", done_cnt - done_b, 0);
    // abort at bit 10 of word 1, then a normal transfer with block_cnt 0
    go(16'd1);
    send_block(d4, -1, -1, 42, 1'b1);
    tick();
    check("ab_wv", wv_cnt - wv_b, 1);
    check("ab_done_err", (done_cnt - done_b) + (err_cnt - err_b), 0);
    check("ab_code", {29'd0, err_code}, 32'd0);
    go(16'd0);
    send_block(d1, -1, -1, -1, 1'b1);
    tick();
    check("re_wv", wv_cnt - wv_b, 2);
    check_words("re", wv_b, d1);
    check("re_done", done_cnt - done_b, 1);
    check("re_err", err_cnt - err_b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
